// File: rtl/conv_window_gen.sv
// Turns a raster-order pixel stream into packed 3x3 windows for the convolution layer.
// Two line buffers hold the previous rows; a 3x3 shift window assembles each output.
module conv_window_gen #(
    parameter int bit_depth = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int CNT_W     = 5
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic                   sof,
    input  logic                   pix_valid,
    input  logic [bit_depth-1:0]   pix_in,
    output logic                   de,
    output logic [bit_depth*9-1:0] win,
    output logic [CNT_W-1:0]       win_row,
    output logic [CNT_W-1:0]       win_col,
    output logic                   frame_done
);

    localparam int IDX_W = $clog2(IMG_W);

    logic [CNT_W-1:0]       row;
    logic [CNT_W-1:0]       col;
    logic [bit_depth-1:0]   lb0 [IMG_W];
    logic [bit_depth-1:0]   lb1 [IMG_W];
    logic [3*bit_depth-1:0] top_row;
    logic [3*bit_depth-1:0] mid_row;
    logic [3*bit_depth-1:0] bot_row;

    logic [CNT_W-1:0]       cur_row;
    logic [CNT_W-1:0]       cur_col;
    logic [CNT_W-1:0]       nxt_row;
    logic [CNT_W-1:0]       nxt_col;
    logic [IDX_W-1:0]       addr;
    logic [bit_depth-1:0]   lb0_rd;
    logic [bit_depth-1:0]   lb1_rd;
    logic [3*bit_depth-1:0] top_nxt;
    logic [3*bit_depth-1:0] mid_nxt;
    logic [3*bit_depth-1:0] bot_nxt;
    logic                   win_ok;
    logic                   last_pix;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        cur_row = row;
        cur_col = col;
        if (sof) begin
            cur_row = '0;
            cur_col = '0;
        end

        addr    = cur_col[IDX_W-1:0];
        lb0_rd  = lb0[addr];
        lb1_rd  = lb1[addr];

        // Leftmost tap sits in the MSBs, so concatenating the rows gives the packed window order.
        top_nxt = {top_row[2*bit_depth-1:0], lb1_rd};
        mid_nxt = {mid_row[2*bit_depth-1:0], lb0_rd};
        bot_nxt = {bot_row[2*bit_depth-1:0], pix_in};

        nxt_row = cur_row;
        nxt_col = cur_col + CNT_W'(1);
        if (cur_col == CNT_W'(IMG_W - 1)) begin
            nxt_col = '0;
            nxt_row = (cur_row == CNT_W'(IMG_H - 1)) ? '0 : cur_row + CNT_W'(1);
        end

        win_ok   = (cur_row >= CNT_W'(2)) && (cur_col >= CNT_W'(2));
        last_pix = (cur_row == CNT_W'(IMG_H - 1)) && (cur_col == CNT_W'(IMG_W - 1));
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            row        <= '0;
            col        <= '0;
            top_row    <= '0;
            mid_row    <= '0;
            bot_row    <= '0;
            de         <= 1'b0;
            frame_done <= 1'b0;
            win        <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            de         <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                row     <= nxt_row;
                col     <= nxt_col;
                top_row <= top_nxt;
                mid_row <= mid_nxt;
                bot_row <= bot_nxt;
                if (win_ok) begin
                    de         <= 1'b1;
                    frame_done <= last_pix;
                    win        <= {top_nxt, mid_nxt, bot_nxt};
                    win_row    <= cur_row - CNT_W'(1);
                    win_col    <= cur_col - CNT_W'(1);
                end
            end else if (sof) begin
                row <= '0;
                col <= '0;
            end
        end
    end

    // NOTE: line buffers are left out of reset so they can map to RAM; stale rows are gated off by win_ok.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[addr] <= lb0_rd;
            lb0[addr] <= pix_in;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image: a frame-store model checks every cycle,
// literal window expectations pin the model at the interesting points of each scenario.
module tb_conv_window_gen;

    localparam int BD = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 3;
    localparam int WB = BD * 9;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [BD-1:0] pix_in = '0;
    logic          de;
    logic          frame_done;
    logic [WB-1:0] win;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;

    conv_window_gen #(.bit_depth(BD), .IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .clk(clk), .RESET(RESET), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .de(de), .win(win), .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WB-1:0] pack9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        return {BD'(a0), BD'(a1), BD'(a2), BD'(a3), BD'(a4), BD'(a5), BD'(a6), BD'(a7), BD'(a8)};
    endfunction

    // Model: a frame store indexed by linear raster position; a window is read straight out of it.
    logic [BD-1:0] img [W*H];
    int            pos;
    logic          exp_de;
    logic          exp_fd;
    logic [WB-1:0] exp_win;
    int            exp_row;
    int            exp_col;

    initial begin
        int p, r, c;
        pos = 0; exp_de = 0; exp_fd = 0; exp_win = '0; exp_row = 0; exp_col = 0;
        forever begin
            @(posedge clk or negedge RESET);
            if (!RESET) begin
                pos = 0; exp_de = 0; exp_fd = 0; exp_win = '0; exp_row = 0; exp_col = 0;
            end else begin
                exp_de = 0;
                exp_fd = 0;
                if (pix_valid) begin
                    p = sof ? 0 : pos;
                    r = p / W;
                    c = p % W;
                    img[p] = pix_in;
                    if (r >= 2 && c >= 2) begin
                        for (int dr = 0; dr < 3; dr++)
                            for (int dc = 0; dc < 3; dc++)
                                exp_win[(8 - (dr*3 + dc))*BD +: BD] = img[(r-2+dr)*W + (c-2+dc)];
                        exp_de  = 1;
                        exp_fd  = (p == W*H - 1);
                        exp_row = r - 1;
                        exp_col = c - 1;
                    end
                    pos = (p + 1) % (W*H);
                end else if (sof) begin
                    pos = 0;
                end
            end
        end
    end

    typedef struct {
        logic [WB-1:0] w;
        int            r;
        int            c;
        logic          fd;
    } win_t;
    win_t log_q[$];

    // Compare process: every cycle, away from the active edge.
    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("de", WB'(de), WB'(exp_de));
                check("frame_done", WB'(frame_done), WB'(exp_fd));
                check("win", win, exp_win);
                check("win_row", WB'(win_row), WB'(CW'(exp_row)));
                check("win_col", WB'(win_col), WB'(CW'(exp_col)));
                if (de) begin
                    e.w = win; e.r = int'(win_row); e.c = int'(win_col); e.fd = frame_done;
                    log_q.push_back(e);
                end
            end
        end
    end

    task automatic send(input int v, input logic s, output logic de_seen);
        @(negedge clk);
        pix_valid = 1'b1;
        sof       = s;
        pix_in    = BD'(v);
        @(posedge clk);
        #1;
        de_seen = de;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    task automatic check_windows(input string tag, input int n_frames);
        int nfd;
        nfd = 0;
        check({tag, "_count"}, WB'(log_q.size()), WB'(4 * n_frames));
        foreach (log_q[i]) if (log_q[i].fd) nfd++;
        check({tag, "_frame_done_count"}, WB'(nfd), WB'(n_frames));
        for (int i = 0; i < log_q.size() && i < 4 * n_frames; i++) begin
            check($sformatf("%s_row_%0d", tag, i), WB'(log_q[i].r), WB'(1 + (i % 4) / 2));
            check($sformatf("%s_col_%0d", tag, i), WB'(log_q[i].c), WB'(1 + i % 2));
            if (i % 4 == 0)
                check($sformatf("%s_first_win_%0d", tag, i), log_q[i].w, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
            if (i % 4 == 3) begin
                check($sformatf("%s_last_win_%0d", tag, i), log_q[i].w, pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
                check($sformatf("%s_last_fd_%0d", tag, i), WB'(log_q[i].fd), WB'(1'b1));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d;
        #1 RESET = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b1;

        // Continuous frame, including row-wrap cycles after pixels 13 and 14.
        log_q.delete();
        for (int k = 1; k <= 16; k++) begin
            send(k, 1'b0, d);
            if (k == 10) check("t1_no_de_after_10", WB'(d), WB'(1'b0));
            if (k == 11) check("t1_first_de_after_11", WB'(d), WB'(1'b1));
            if (k == 13) check("t1_row_wrap_13", WB'(d), WB'(1'b0));
            if (k == 14) check("t1_row_wrap_14", WB'(d), WB'(1'b0));
        end
        idle(3);
        check_windows("t1", 1);

        // Same frame with a bubble after every pixel.
        log_q.delete();
        for (int k = 1; k <= 16; k++) begin
            send(k, 1'b0, d);
            idle(1);
        end
        idle(3);
        check_windows("t2", 1);

        // Two frames back to back.
        log_q.delete();
        for (int k = 0; k < 32; k++) send((k % 16) + 1, 1'b0, d);
        idle(3);
        check_windows("t3", 2);

        // Asynchronous reset mid-frame.
        log_q.delete();
        for (int k = 1; k <= 7; k++) send(k, 1'b0, d);
        #1 RESET = 1'b0;
        #1;
        check("t4_rst_de", WB'(de), WB'(1'b0));
        check("t4_rst_win", win, '0);
        check("t4_rst_frame_done", WB'(frame_done), WB'(1'b0));
        idle(3);
        @(negedge clk);
        RESET = 1'b1;
        for (int k = 1; k <= 16; k++) send(k, 1'b0, d);
        idle(3);
        check_windows("t4", 1);

        // sof with a new frame's first pixel after pixel 9.
        log_q.delete();
        for (int k = 1; k <= 9; k++) send(k, 1'b0, d);
        send(1, 1'b1, d);
        for (int k = 2; k <= 16; k++) begin
            send(k, 1'b0, d);
            if (k == 10) check("t5_no_de_after_10", WB'(d), WB'(1'b0));
            if (k == 11) check("t5_first_de_after_11", WB'(d), WB'(1'b1));
        end
        idle(3);
        check_windows("t5", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
